regfile_arbiter_8085: RTL and testbench
=======================================

Name: regfile_arbiter_8085

Overview:
- Owns the 7 x 8-bit general register file (B,C,D,E,H,L,M-temp at addresses 0..6) of the 8085 single-cycle datapath.
- Shares the file between two requesters: the processor core port (core_*) and a debug/preload port (dbg_*).
- The debug port lets a bench or monitor load and read registers while the core runs.
- Performs one access per clock, with starvation-bounded priority to the core.

Parameters:
- NREG, 7, number of implemented registers; valid addresses 0..NREG-1.
- DW, 8, data width.
- AW, 3, address width.
- STARVE_LIMIT, 4, consecutive denied dbg cycles before dbg is forced to win one arbitration.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- core_req  input  1  core access request; held until core_gnt.
- core_we  input  1  1 = write, 0 = read.
- core_addr  input  AW  register index.
- core_wdata  input  DW  write data.
- core_gnt  output  1  combinational grant; access commits at this clock edge.
- core_rvalid  output  1  registered; read data valid one cycle after a read grant.
- core_rdata  output  DW  registered read data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same directions, widths and meanings for the debug port.

Behaviour:
- Reset (rst=1 at posedge):
  - all NREG registers become 8'h00.
  - *_rvalid=0 and *_rdata=8'h00.
  - starve_cnt=0 and last_gnt=core.
  - while rst=1, core_gnt=dbg_gnt=0 and no access is performed. rst overrides any in-flight request. A read granted in the cycle before rst produces no rvalid.
- Arbitration (combinational, same cycle):
  - only one requester: it is granted.
  - both request: core is granted, unless starve_cnt==STARVE_LIMIT, in which case dbg is granted.
  - at most one gnt is high in any cycle.
- Starvation counter:
  - increments when dbg_req=1 and dbg_gnt=0, saturating at STARVE_LIMIT.
  - clears to 0 on dbg_gnt or when dbg_req=0.
- Granted write: reg[addr] <= wdata at the granting edge.
- Granted read:
  - at the granting edge, rdata <= reg[addr] (value before any same-edge write) and rvalid <= 1 for that port only.
  - rvalid is a single-cycle pulse; rdata holds its value until the next read grant to that port.
- Read-after-write: a read granted in cycle N+1 returns data written in cycle N.
- Out-of-range address (addr >= NREG, i.e. 7):
  - the request is still granted.
  - a write is discarded.
  - a read returns 8'h00 with rvalid=1.
- Requesters must hold req/we/addr/wdata stable until gnt. Behaviour when req drops before gnt: the request is simply withdrawn, no side effects.
- Back-to-back: the same port may be granted every cycle. Throughput is 1 access/cycle total.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - when both request, the grant alternates using last_gnt: the port not granted last wins.
  - last_gnt updates on every grant.
  - starve_cnt and STARVE_LIMIT are unused; the counter is not synthesized.
- Undefined: fixed core priority with the starvation override described above.

Test Plan:
- Reset then dbg reads addr 0..6 -> each dbg_rvalid pulse carries 8'h00.
- dbg writes reg[i]=i+1 for i=0..6, core idle -> 7 consecutive dbg_gnt. Core then reads addr 2 -> core_rdata=8'h03 one cycle after core_gnt.
- Core and dbg request continuously (macro off, STARVE_LIMIT=4) -> grant pattern core,core,core,core,dbg repeating. No cycle has both gnt high.
- Core writes addr 3 = 8'hA5 in cycle N, dbg reads addr 3 in cycle N+1 -> dbg_rdata=8'hA5. Core write to addr 7 = 8'hFF -> file unchanged; read of addr 7 returns 8'h00.
- rst asserted the cycle after a core read grant of addr 0 (=8'h01) -> core_rvalid stays 0, all registers read 8'h00 after rst is released.
- Macro on, both requesting continuously -> grants alternate dbg,core,dbg,... starting with dbg (last_gnt=core after reset).

Source files
------------

// File: rtl/regfile_arbiter_8085.sv
// Shared 7x8 register file for the 8085 datapath, arbitrated between core and debug ports.
// Optional `ARB_ROUND_ROBIN_EN replaces core priority + starvation override with alternating grants.
module regfile_arbiter_8085 #(
  parameter int NREG         = 7,
  parameter int DW           = 8,
  parameter int AW           = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata
);

  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  logic [DW-1:0] regs [NREG];

  logic          dbg_wins;
  logic          acc_vld_p0;
  logic          acc_we_p0;
  logic [AW-1:0] acc_addr_p0;
  logic [DW-1:0] acc_wdata_p0;
  logic          acc_in_range_p0;
  logic [DW-1:0] acc_rd_p0;

  logic          core_rvalid_p1;
  logic [DW-1:0] core_rdata_p1;
  logic          dbg_rvalid_p1;
  logic [DW-1:0] dbg_rdata_p1;

`ifdef ARB_ROUND_ROBIN_EN
  typedef enum logic {GNT_CORE, GNT_DBG} gnt_t;
  gnt_t last_gnt;

  always_ff @(posedge clk) begin
    if (rst)           last_gnt <= GNT_CORE;
    else if (core_gnt) last_gnt <= GNT_CORE;
    else if (dbg_gnt)  last_gnt <= GNT_DBG;
  end

  assign dbg_wins = (last_gnt == GNT_CORE);
`else
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == SW'(STARVE_LIMIT)) ? v : v + SW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst)                      starve_cnt <= '0;
    else if (!dbg_req || dbg_gnt) starve_cnt <= '0;
    else                          starve_cnt <= sat_inc(starve_cnt);
  end

  assign dbg_wins = (starve_cnt == SW'(STARVE_LIMIT));
`endif

  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    if (!rst) begin
      if (core_req && dbg_req) begin
        dbg_gnt  = dbg_wins;
        core_gnt = !dbg_wins;
      end else begin
        core_gnt = core_req;
        dbg_gnt  = dbg_req;
      end
    end
  end

  // Stage p0: select the granted port's access and look up read data
  always_comb begin
    acc_vld_p0      = core_gnt | dbg_gnt;
    acc_we_p0       = core_gnt ? core_we    : dbg_we;
    acc_addr_p0     = core_gnt ? core_addr  : dbg_addr;
    acc_wdata_p0    = core_gnt ? core_wdata : dbg_wdata;
    acc_in_range_p0 = ({1'b0, acc_addr_p0} < NREG_W);
    acc_rd_p0       = acc_in_range_p0 ? regs[acc_addr_p0] : '0;
  end

  // Stage p1: commit writes, register read results
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      core_rvalid_p1 <= 1'b0;
      core_rdata_p1  <= '0;
      dbg_rvalid_p1  <= 1'b0;
      dbg_rdata_p1   <= '0;
    end else begin
      if (acc_vld_p0 && acc_we_p0 && acc_in_range_p0)
        regs[acc_addr_p0] <= acc_wdata_p0;
      core_rvalid_p1 <= core_gnt && !core_we;
      dbg_rvalid_p1  <= dbg_gnt && !dbg_we;
      if (core_gnt && !core_we) core_rdata_p1 <= acc_rd_p0;
      if (dbg_gnt && !dbg_we)   dbg_rdata_p1  <= acc_rd_p0;
    end
  end

  // A read granted just before reset must not surface while reset is asserted
  assign core_rvalid = core_rvalid_p1 & ~rst;
  assign dbg_rvalid  = dbg_rvalid_p1 & ~rst;
  assign core_rdata  = core_rdata_p1;
  assign dbg_rdata   = dbg_rdata_p1;

endmodule

// File: tb/tb_regfile_arbiter_8085.sv
// Scoreboard bench for regfile_arbiter_8085: stimulus queues expected reads/grants, monitor checks.
module tb_regfile_arbiter_8085;

  logic       clk = 1'b0;
  logic       rst;
  logic       core_req, core_we, core_gnt, core_rvalid;
  logic [2:0] core_addr;
  logic [7:0] core_wdata, core_rdata;
  logic       dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_wdata, dbg_rdata;

  int checks   = 0;
  int failures = 0;

  logic [7:0] cq[$];
  logic [7:0] dq[$];
  logic [1:0] gq[$];
  logic       gchk = 1'b0;

  regfile_arbiter_8085 dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant/read result
  initial begin
    forever begin
      @(negedge clk);
      check("one_hot_gnt", {7'd0, core_gnt & dbg_gnt}, 8'h00);
      if (gchk) begin
        if (gq.size() == 0) check("gnt_queue_empty", 8'h01, 8'h00);
        else check("gnt_pattern", {6'd0, core_gnt, dbg_gnt}, {6'd0, gq.pop_front()});
      end
      if (core_rvalid) begin
        if (cq.size() == 0) check("core_unexpected_rvalid", core_rdata, 8'hxx);
        else check("core_rdata", core_rdata, cq.pop_front());
      end
      if (dbg_rvalid) begin
        if (dq.size() == 0) check("dbg_unexpected_rvalid", dbg_rdata, 8'hxx);
        else check("dbg_rdata", dbg_rdata, dq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  task automatic access(input bit is_dbg, input bit we, input logic [2:0] a,
                        input logic [7:0] wd, input logic [7:0] exp, input bit push_exp);
    int  n;
    logic g;
    if (!we && push_exp) begin
      if (is_dbg) dq.push_back(exp);
      else        cq.push_back(exp);
    end
    if (is_dbg) begin dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = wd; end
    else        begin core_req = 1; core_we = we; core_addr = a; core_wdata = wd; end
    n = 0;
    forever begin
      @(negedge clk);
      g = is_dbg ? dbg_gnt : core_gnt;
      if (g) break;
      n++;
      if (n >= 20) begin
        checks++;
        failures++;
        $display("FAIL access_timeout actual=no_gnt expected=gnt port=%0d", is_dbg);
        break;
      end
    end
    @(posedge clk); #1;
    if (is_dbg) dbg_req = 0;
    else        core_req = 0;
  endtask

  initial begin
    logic [7:0] exp_file [7];
    rst = 1; core_req = 1; core_we = 0; core_addr = 0; core_wdata = 0;
    dbg_req = 1; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;

    // Reset: no grants while rst is high, outputs cleared
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_core_gnt", {7'd0, core_gnt}, 8'h00);
    check("rst_dbg_gnt", {7'd0, dbg_gnt}, 8'h00);
    @(posedge clk); #1;
    rst = 0; core_req = 0; dbg_req = 0;
    @(negedge clk);
    check("rst_core_rvalid", {7'd0, core_rvalid}, 8'h00);
    check("rst_dbg_rvalid", {7'd0, dbg_rvalid}, 8'h00);
    check("rst_core_rdata", core_rdata, 8'h00);
    check("rst_dbg_rdata", dbg_rdata, 8'h00);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) access(1, 0, 3'(i), 8'h00, 8'h00, 1);

    // Seven back-to-back debug writes, each granted in its own cycle
    gchk = 1;
    for (int i = 0; i < 7; i++) begin
      dbg_req = 1; dbg_we = 1; dbg_addr = 3'(i); dbg_wdata = 8'(i + 1);
      gq.push_back(2'b01);
      @(posedge clk); #1;
    end
    dbg_req = 0; gchk = 0;

    access(0, 0, 3'd2, 8'h00, 8'h03, 1);

    // Contention: both ports write the out-of-range address continuously
    core_req = 1; core_we = 1; core_addr = 3'd7; core_wdata = 8'h5A;
    dbg_req = 1;  dbg_we = 1;  dbg_addr = 3'd7;  dbg_wdata = 8'hC3;
    for (int i = 0; i < 10; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      gq.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
`else
      gq.push_back((i % 5 == 4) ? 2'b01 : 2'b10);
`endif
    end
    gchk = 1;
    repeat (10) @(posedge clk);
    #1;
    core_req = 0; dbg_req = 0; gchk = 0;

    // Read-after-write across ports, then out-of-range write/read
    access(0, 1, 3'd3, 8'hA5, 8'h00, 0);
    access(1, 0, 3'd3, 8'h00, 8'hA5, 1);
    access(0, 1, 3'd7, 8'hFF, 8'h00, 0);
    access(1, 0, 3'd7, 8'h00, 8'h00, 1);
    exp_file = '{8'h01, 8'h02, 8'h03, 8'hA5, 8'h05, 8'h06, 8'h07};
    for (int i = 0; i < 7; i++) access(1, 0, 3'(i), 8'h00, exp_file[i], 1);

    // Reset right after a core read grant: no rvalid, file cleared
    access(0, 0, 3'd0, 8'h00, 8'h01, 0);
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 7; i++) access(1, 0, 3'(i), 8'h00, 8'h00, 1);

    repeat (3) @(negedge clk);
    check("core_queue_drained", 8'(cq.size()), 8'h00);
    check("dbg_queue_drained", 8'(dq.size()), 8'h00);
    check("gnt_queue_drained", 8'(gq.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
